// File: rtl/fwd_addr_gen_state.sv
// Forward-pass write-address generator for one LSTM layer: act/c/h write strobes and addresses.
// Optional build macro FWD_ADDR_REVERSE_EN: write addresses become TOTAL-1-k instead of k.
module fwd_addr_gen_state #(
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_CELL   = 53,
    parameter int TIMESTEP   = 7,
    parameter int DELAY_C    = 2,
    parameter int DELAY_H    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  i_valid,
    output logic                  wr_act,
    output logic [ADDR_WIDTH-1:0] o_addr_act,
    output logic                  wr_c,
    output logic [ADDR_WIDTH-1:0] o_addr_c,
    output logic                  wr_h,
    output logic [ADDR_WIDTH-1:0] o_addr_h,
    output logic [ADDR_WIDTH-1:0] o_t,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_K = ADDR_WIDTH'(NUM_CELL * TIMESTEP - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_N = ADDR_WIDTH'(NUM_CELL - 1);
    localparam int                    DCW    = (DELAY_H > 1) ? $clog2(DELAY_H) : 1;
    localparam logic [DCW-1:0]        DRAIN_LAST = DCW'(DELAY_H - 1);

    state_t                state_r;
    logic                  en_prev_r;
    logic [ADDR_WIDTH-1:0] k_r;
    logic [ADDR_WIDTH-1:0] n_r;
    logic [ADDR_WIDTH-1:0] t_r;
    logic [DCW-1:0]        drain_cnt_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  overflow_r;
    logic [DELAY_H:1]      pv_r;
    logic [ADDR_WIDTH-1:0] pa_r [1:DELAY_H];

    logic                  en_rise_s;
    logic                  accept_s;
    logic                  abort_s;
    logic                  stray_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s;

    // Control decode and write-address selection for the cell being accepted.
    always_comb begin
        en_rise_s = en & ~en_prev_r;
        accept_s  = (state_r == ST_RUN) & en & i_valid;
        abort_s   = ((state_r == ST_RUN) | (state_r == ST_DRAIN)) & ~en;
        stray_s   = i_valid & (state_r != ST_RUN);
`ifdef FWD_ADDR_REVERSE_EN
        wr_addr_s = LAST_K - k_r;
`else
        wr_addr_s = k_r;
`endif
    end

    // Pass sequencing FSM with entry counters and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            en_prev_r   <= 1'b1;   // a held-high en after reset is not a start request
            k_r         <= '0;
            n_r         <= '0;
            t_r         <= '0;
            drain_cnt_r <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            en_prev_r <= en;
            done_r    <= 1'b0;
            if (stray_s) begin
                overflow_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (en_rise_s) begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                        k_r     <= '0;
                        n_r     <= '0;
                        t_r     <= '0;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        k_r     <= '0;
                        n_r     <= '0;
                        t_r     <= '0;
                    end else if (i_valid) begin
                        k_r <= k_r + ADDR_WIDTH'(1);
                        if (n_r == LAST_N) begin
                            n_r <= '0;
                            t_r <= t_r + ADDR_WIDTH'(1);
                        end else begin
                            n_r <= n_r + ADDR_WIDTH'(1);
                        end
                        if (k_r == LAST_K) begin
                            state_r     <= ST_DRAIN;
                            drain_cnt_r <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!en) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        k_r     <= '0;
                        n_r     <= '0;
                        t_r     <= '0;
                    end else if (drain_cnt_r == DRAIN_LAST) begin
                        // last wr_h is on the port this cycle
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + DCW'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Write pipeline: valid bit and address per stage; addresses hold when no entry passes.
    always_ff @(posedge clk) begin
        if (rst) begin
            pv_r <= '0;
            for (int i = 1; i <= DELAY_H; i++) begin
                pa_r[i] <= '0;
            end
        end else if (abort_s) begin
            pv_r <= '0;
        end else begin
            pv_r[1] <= accept_s;
            if (accept_s) begin
                pa_r[1] <= wr_addr_s;
            end
            for (int i = 2; i <= DELAY_H; i++) begin
                pv_r[i] <= pv_r[i-1];
                if (pv_r[i-1]) begin
                    pa_r[i] <= pa_r[i-1];
                end
            end
        end
    end

    assign wr_act     = pv_r[1];
    assign o_addr_act = pa_r[1];
    assign wr_c       = pv_r[DELAY_C];
    assign o_addr_c   = pa_r[DELAY_C];
    assign wr_h       = pv_r[DELAY_H];
    assign o_addr_h   = pa_r[DELAY_H];
    assign o_t        = t_r;
    assign o_busy     = busy_r;
    assign o_done     = done_r;
    assign o_overflow = overflow_r;

endmodule

// File: tb/tb_fwd_addr_gen_state.sv
// Scoreboard bench for fwd_addr_gen_state: a pass-level reference model queues expected
// strobes/status per cycle; a negedge monitor pops and compares. Honours FWD_ADDR_REVERSE_EN.
module tb_fwd_addr_gen_state;
    localparam int AW    = 12;
    localparam int NC    = 3;
    localparam int TS    = 2;
    localparam int DC    = 2;
    localparam int DH    = 4;
    localparam int TOTAL = NC * TS;

    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          i_valid;
    logic          wr_act;
    logic [AW-1:0] o_addr_act;
    logic          wr_c;
    logic [AW-1:0] o_addr_c;
    logic          wr_h;
    logic [AW-1:0] o_addr_h;
    logic [AW-1:0] o_t;
    logic          o_busy;
    logic          o_done;
    logic          o_overflow;

    always #5 clk = ~clk;

    fwd_addr_gen_state #(
        .ADDR_WIDTH(AW), .NUM_CELL(NC), .TIMESTEP(TS), .DELAY_C(DC), .DELAY_H(DH)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .i_valid(i_valid),
        .wr_act(wr_act), .o_addr_act(o_addr_act),
        .wr_c(wr_c), .o_addr_c(o_addr_c),
        .wr_h(wr_h), .o_addr_h(o_addr_h),
        .o_t(o_t), .o_busy(o_busy), .o_done(o_done), .o_overflow(o_overflow)
    );

    typedef struct { int cyc; logic [AW-1:0] addr; } ev_t;
    typedef struct { int cyc; logic busy; logic [AW-1:0] t; logic ovf; } st_t;

    ev_t q_act[$];
    ev_t q_c[$];
    ev_t q_h[$];
    ev_t q_done[$];
    st_t q_st[$];

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   m_phase = P_IDLE;
    int   m_cnt = 0;
    int   m_last = 0;
    logic m_en_prev = 1'b1;
    logic m_ovf = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [AW-1:0] addr_of(input int k);
`ifdef FWD_ADDR_REVERSE_EN
        return AW'(TOTAL - 1 - k);
`else
        return AW'(k);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Drop everything scheduled after cycle t (squash by abort or reset).
    task automatic prune(input int t);
        while (q_act.size() > 0 && q_act[q_act.size()-1].cyc > t) q_act.delete(q_act.size()-1);
        while (q_c.size() > 0 && q_c[q_c.size()-1].cyc > t) q_c.delete(q_c.size()-1);
        while (q_h.size() > 0 && q_h[q_h.size()-1].cyc > t) q_h.delete(q_h.size()-1);
        while (q_done.size() > 0 && q_done[q_done.size()-1].cyc > t) q_done.delete(q_done.size()-1);
    endtask

    // Drive one cycle of inputs, predict what the DUT shows next cycle, advance the clock.
    task automatic step(input logic r, input logic e, input logic v);
        int t;
        st_t s;
        t = cyc;
        rst = r;
        en = e;
        i_valid = v;
        if (r) begin
            prune(t);
            m_phase = P_IDLE;
            m_cnt = 0;
            m_ovf = 1'b0;
            m_en_prev = 1'b1;
        end else begin
            case (m_phase)
                P_IDLE: begin
                    if (v) m_ovf = 1'b1;
                    if (e && !m_en_prev) begin
                        m_phase = P_RUN;
                        m_cnt = 0;
                    end
                end
                P_RUN: begin
                    if (!e) begin
                        prune(t);
                        m_phase = P_IDLE;
                        m_cnt = 0;
                    end else if (v) begin
                        q_act.push_back('{t + 1, addr_of(m_cnt)});
                        q_c.push_back('{t + DC, addr_of(m_cnt)});
                        q_h.push_back('{t + DH, addr_of(m_cnt)});
                        m_cnt++;
                        if (m_cnt == TOTAL) begin
                            m_phase = P_DRAIN;
                            m_last = t;
                        end
                    end
                end
                P_DRAIN: begin
                    if (v) m_ovf = 1'b1;
                    if (!e) begin
                        prune(t);
                        m_phase = P_IDLE;
                        m_cnt = 0;
                    end else if (t == m_last + DH) begin
                        m_phase = P_DONE;
                        q_done.push_back('{t + 1, '0});
                    end
                end
                default: begin
                    if (v) m_ovf = 1'b1;
                    m_phase = P_IDLE;
                end
            endcase
            m_en_prev = e;
        end
        s.cyc  = t + 1;
        s.busy = (m_phase == P_RUN) || (m_phase == P_DRAIN);
        s.t    = AW'(m_cnt / NC);
        s.ovf  = m_ovf;
        q_st.push_back(s);
        @(posedge clk);
        #1;
    endtask

    // One strobe channel: pop its due entry and compare strobe and address.
    task automatic chk_strobe(input int kind, input logic stb, input logic [AW-1:0] addr);
        ev_t  e;
        logic has;
        string nm;
        has = 1'b0;
        e = '{0, '0};
        case (kind)
            0: begin nm = "wr_act"; if (q_act.size() > 0 && q_act[0].cyc <= cyc) begin e = q_act.pop_front(); has = 1'b1; end end
            1: begin nm = "wr_c";   if (q_c.size() > 0 && q_c[0].cyc <= cyc) begin e = q_c.pop_front(); has = 1'b1; end end
            2: begin nm = "wr_h";   if (q_h.size() > 0 && q_h[0].cyc <= cyc) begin e = q_h.pop_front(); has = 1'b1; end end
            default: begin nm = "o_done"; if (q_done.size() > 0 && q_done[0].cyc <= cyc) begin e = q_done.pop_front(); has = 1'b1; end end
        endcase
        if (has || stb) begin
            chk(nm, 32'(stb), 32'(has && (e.cyc == cyc)));
            if (stb && has && kind != 3) chk({nm, "_addr"}, 32'(addr), 32'(e.addr));
        end
    endtask

    // Monitor: compare every visible output against the scoreboard each cycle.
    initial begin
        st_t s;
        forever begin
            @(negedge clk);
            if (q_st.size() > 0 && q_st[0].cyc == cyc) begin
                s = q_st.pop_front();
                chk("o_busy", 32'(o_busy), 32'(s.busy));
                chk("o_t", 32'(o_t), 32'(s.t));
                chk("o_overflow", 32'(o_overflow), 32'(s.ovf));
                chk_strobe(0, wr_act, o_addr_act);
                chk_strobe(1, wr_c, o_addr_c);
                chk_strobe(2, wr_h, o_addr_h);
                chk_strobe(3, o_done, '0);
            end
        end
    end

    task automatic idle_cycles(input logic e, input int n);
        for (int i = 0; i < n; i++) step(1'b0, e, 1'b0);
    endtask

    initial begin
        // reset with en and i_valid high; held en must not start a pass
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        idle_cycles(1'b1, 3);
        idle_cycles(1'b0, 1);

        // normal pass, i_valid every third cycle
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < TOTAL; i++) begin
            step(1'b0, 1'b1, 1'b1);
            idle_cycles(1'b1, 2);
        end
        idle_cycles(1'b1, 8);
        idle_cycles(1'b0, 1);

        // back-to-back accepts
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < TOTAL; i++) step(1'b0, 1'b1, 1'b1);
        idle_cycles(1'b1, 8);
        idle_cycles(1'b0, 1);

        // abort after the 4th accept with writes in flight, then restart
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        idle_cycles(1'b0, 5);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < TOTAL; i++) step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);   // stray i_valid in DRAIN
        idle_cycles(1'b1, 8);
        idle_cycles(1'b0, 1);

        // overflow must persist through another full pass
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < TOTAL; i++) begin
            step(1'b0, 1'b1, 1'b1);
            idle_cycles(1'b1, 1);
        end
        idle_cycles(1'b1, 8);

        // randomized passes with occasional aborts and resets
        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(0, 9) == 0) step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            idle_cycles(1'b0, $urandom_range(1, 2));
            for (int c = 0; c < 40; c++) begin
                if ($urandom_range(0, 39) == 0) begin
                    step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
                    break;
                end
                step(1'b0, 1'b1, 1'($urandom_range(0, 2) != 0));
                if (m_phase == P_IDLE && c > 2) break;
            end
        end
        idle_cycles(1'b0, DH + 4);
        @(negedge clk);
        #1;
        chk("leftover_events", 32'(q_act.size() + q_c.size() + q_h.size() + q_done.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
